wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter W, default 32, register data width.
REQ-002 Parameter N, default 32, number of architectural registers; address width AW = $clog2(N).
REQ-003 Parameter DEPTH, default 2, write-buffer entries; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 alu_valid / alu_rd / alu_data  in  1 / AW / W  ALU result offer.
REQ-007 alu_ready  out  1  ALU offer accepted this cycle when high together with alu_valid.
REQ-008 ld_valid / ld_rd / ld_data  in  1 / AW / W  load-unit result offer.
REQ-009 ld_ready  out  1  load offer accepted this cycle when high together with ld_valid.
REQ-010 port_busy  in  1  regfile write port is taken by debug this cycle; no write may issue.
REQ-011 wen / waddr / wdata  out  1 / AW / W  regfile write port; drives regfile_ff wen/waddr/wdata directly.
REQ-012 wb_idle  out  1  high when the buffer is empty.

Function
REQ-013 Handshake: transfer occurs when valid and ready are both high; a source holds rd and data stable while valid is high and ready is low.
REQ-014 ready is a combinational function of buffer occupancy, both valids and the arbiter state; ready never depends on data or rd.
REQ-015 At most one source is accepted per cycle.
REQ-016 Arbitration: one source valid -> that source is granted; both valid -> the source not accepted last is granted (round-robin).
REQ-017 The last-accepted register updates only on an accepted transfer; it holds otherwise.
REQ-018 Buffer full -> alu_ready = ld_ready = 0, including in a cycle where a pop occurs (no same-cycle push-through when full).
REQ-019 Accepted write with rd = 0 completes the handshake and is discarded; it is never pushed and never produces wen.
REQ-020 Accepted write with rd != 0 is pushed at the clock edge.
REQ-021 wen = !empty && !port_busy, combinational; waddr/wdata = buffer head; pop occurs on every cycle in which wen = 1.
REQ-022 Latency: accepted in cycle N into an empty buffer with port_busy = 0 -> wen = 1 in cycle N+1.
REQ-023 Writes issue in strict acceptance order; none are dropped, duplicated or reordered.
REQ-024 Buffer pointers wrap modulo DEPTH; occupancy counter range is 0..DEPTH.
REQ-025 Simultaneous push and pop when not full -> occupancy unchanged, head advances.
REQ-026 port_busy high -> wen = 0, no pop, buffer contents preserved; acceptance continues until full.
REQ-027 waddr and wdata are don't-care when wen = 0, but are driven with no X.

Reset
REQ-028 rst_n low at a rising edge -> buffer emptied, pointers and count = 0, last-accepted = ALU.
REQ-029 Outputs during and after reset until first accept: wen = 0, wb_idle = 1, waddr = 0, wdata = 0.
REQ-030 Reset mid-operation discards all buffered writes; none reach the port after rst_n rises.
REQ-031 While rst_n is low, alu_ready = ld_ready = 0.

Structure
REQ-032 Shared package rv_pkg holds XLEN = 32, NREGS = 32, REG_AW = 5, and the typedef wb_req_t {rd, data}.
REQ-033 Sub-module wb_fifo (DEPTH-entry synchronous FIFO with push, pop, full, empty) holds the buffer; arbitration and x0 filtering live in wb_arbiter.

Verification
REQ-034 Reset, then ALU alone sends rd=5, data=0xDEADBEEF in cycle 1 -> wen=1, waddr=5, wdata=0xDEADBEEF in cycle 2; wb_idle=1 in cycle 3.
REQ-035 Both valid every cycle after reset, alu rd=1, ld rd=2 -> acceptance order LD, ALU, LD, ALU; waddr sequence 2,1,2,1.
REQ-036 ALU sends rd=0, data=0x1234 -> alu_ready=1, no wen in any later cycle.
REQ-037 port_busy held high for 4 cycles while ALU streams rd=3,4,5 -> first two accepted, alu_ready=0 while full; after release, waddr 3,4,5 in consecutive cycles.
REQ-038 Buffer holding 2 entries, rst_n low for 1 cycle -> wen=0 thereafter and no entry written.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared core widths, write-back request type and source encoding
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - result offers from ALU/load unit and the regfile write port
interface wb_arbiter_if
    import rv_pkg::*;
#(
    parameter int W  = XLEN,
    parameter int AW = REG_AW
);

    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [W-1:0]  alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd;
    logic [W-1:0]  ld_data;
    logic          port_busy;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          wb_idle;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output port_busy,
        input  wen, waddr, wdata, wb_idle
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  port_busy,
        output wen, waddr, wdata, wb_idle
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry synchronous FIFO holding pending regfile writes
module wb_fifo
    import rv_pkg::*;
#(
    parameter int WIDTH = REG_AW + XLEN,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;

    // Storage carries no reset; the head is masked by the caller whenever it is not valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    assign dout  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin write-back arbiter with x0 filtering and a write buffer
module wb_arbiter
    import rv_pkg::*;
#(
    parameter int W     = XLEN,
    parameter int N     = NREGS,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    localparam int AW = $clog2(N);

    src_t          last_q;
    src_t          last_d;
    logic          full;
    logic          empty;
    logic          can_accept;
    logic          pick_ld;
    logic          alu_acc;
    logic          ld_acc;
    logic          push;
    logic          pop;
    logic          wen;
    logic [AW-1:0] acc_rd;
    logic [W-1:0]  acc_data;
    logic [AW+W-1:0] head;

    // A full buffer refuses both sources even if it drains this cycle.
    assign can_accept = rst_n && !full;
    assign pick_ld    = bus.ld_valid && (!bus.alu_valid || (last_q == SRC_ALU));

    assign bus.alu_ready = can_accept && !pick_ld;
    assign bus.ld_ready  = can_accept && pick_ld;

    assign alu_acc  = bus.alu_valid && bus.alu_ready;
    assign ld_acc   = bus.ld_valid && bus.ld_ready;
    assign acc_rd   = ld_acc ? bus.ld_rd   : bus.alu_rd;
    assign acc_data = ld_acc ? bus.ld_data : bus.alu_data;

    // Writes to x0 finish the handshake but never enter the buffer.
    assign push = (alu_acc || ld_acc) && (acc_rd != '0);
    assign wen  = rst_n && !empty && !bus.port_busy;
    assign pop  = wen;

    always_comb begin
        last_d = last_q;
        if (ld_acc) begin
            last_d = SRC_LD;
        end else if (alu_acc) begin
            last_d = SRC_ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= SRC_ALU;
        end else begin
            last_q <= last_d;
        end
    end

    wb_fifo #(
        .WIDTH (AW + W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({acc_rd, acc_data}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.wen     = wen;
    assign bus.waddr   = wen ? head[AW+W-1:W] : '0;
    assign bus.wdata   = wen ? head[W-1:0]    : '0;
    assign bus.wb_idle = empty || !rst_n;

endmodule
